// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the MEM stage. Each granted request becomes N byte transfers that are
// assembled or split little-endian, then a single-cycle done pulse.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on a tie); when it is
// undefined, MEM has fixed priority over IF.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic                  flush_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [31:0]           if_data_o,
    output logic                  if_done_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_len_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_done_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    state_t                r_state;
    state_t                w_next_state;
    owner_t                r_owner;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [2:0]            r_len;    // byte count N: 1, 2 or 4
    logic [2:0]            r_cnt;    // XFER cycle index 0..N
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [31:0]           r_data;

    logic                  w_if_ok;
    logic                  w_grant_mem;
    logic                  w_grant_if;
    logic [2:0]            w_mem_len;
    logic [1:0]            w_cap_idx;
    logic                  w_issue;
    logic                  w_done;

`ifdef MEM_ARB_RR_EN
    owner_t                r_last;   // requester served by the most recent grant
`endif

    // Byte lane receiving ram_din_i: the data arriving now belongs to the
    // address presented one cycle earlier.
    assign w_cap_idx = r_cnt[1:0] - 2'd1;

    // Arbitration: a flush in IDLE removes the IF request for that cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_if_ok     = if_req_i & ~flush_i;
        w_grant_mem = mem_req_i;
        w_grant_if  = w_if_ok & ~mem_req_i;
`ifdef MEM_ARB_RR_EN
        if (mem_req_i && w_if_ok) begin
            w_grant_mem = (r_last == OWN_IF);
            w_grant_if  = (r_last == OWN_MEM);
        end
`endif
    end

    // Decode the MEM transfer length into a byte count.
    always_comb begin
        case (mem_len_i)
            2'b00:   w_mem_len = 3'd1;
            2'b01:   w_mem_len = 3'd2;
            default: w_mem_len = 3'd4;
        endcase
    end

    // Next-state logic; a flush only aborts transfers owned by IF.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_mem || w_grant_if) begin
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                if (flush_i && (r_owner == OWN_IF)) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == r_len) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register and transfer datapath; everything holds while rdy_in is low.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IF;
            r_base  <= '0;
            r_len   <= 3'd0;
            r_cnt   <= 3'd0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_data  <= '0;
        end else if (rdy_in) begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= 3'd0;
                    r_data <= '0;
                    if (w_grant_mem) begin
                        r_owner <= OWN_MEM;
                        r_base  <= mem_addr_i;
                        r_len   <= w_mem_len;
                        r_we    <= mem_we_i;
                        r_wdata <= mem_wdata_i;
                    end else if (w_grant_if) begin
                        r_owner <= OWN_IF;
                        r_base  <= if_addr_i;
                        r_len   <= 3'd4;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                    end
                end
                ST_XFER: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (!r_we && (r_cnt != 3'd0)) begin
                        r_data[{w_cap_idx, 3'b000} +: 8] <= ram_din_i;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was granted last so the next tie goes to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= OWN_IF;
        end else if (rdy_in && (r_state == ST_IDLE)) begin
            if (w_grant_mem) begin
                r_last <= OWN_MEM;
            end else if (w_grant_if) begin
                r_last <= OWN_IF;
            end
        end
    end
`endif

    // RAM port and requester outputs, all decoded from registered state.
    always_comb begin
        w_issue     = (r_state == ST_XFER) && (r_cnt < r_len);
        w_done      = (r_state == ST_DONE) && rdy_in;
        ram_a_o     = '0;
        ram_dout_o  = 8'h00;
        if (w_issue) begin
            ram_a_o = r_base + ADDR_WIDTH'(r_cnt);
        end
        if (w_issue && r_we) begin
            ram_dout_o = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        end
        ram_wr_o    = w_issue & r_we & rdy_in;
        if_done_o   = w_done && (r_owner == OWN_IF) && !flush_i;
        mem_done_o  = w_done && (r_owner == OWN_MEM);
        if_data_o   = ((r_state == ST_DONE) && (r_owner == OWN_IF))  ? r_data : 32'h0;
        mem_rdata_o = ((r_state == ST_DONE) && (r_owner == OWN_MEM)) ? r_data : 32'h0;
        busy_o      = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven checks of mem_arbiter against a
// byte RAM model, plus hand-written sequences for ties, flush, pause, reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy_in;
    logic        flush_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic        busy_o;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy_in      (rdy_in),
        .flush_i     (flush_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_done_o   (if_done_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_len_i   (mem_len_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_done_o  (mem_done_o),
        .ram_a_o     (ram_a_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " ctl"}, {ram_a_o, ram_dout_o, ram_wr_o, busy_o, if_done_o, mem_done_o}, 64'h0);
        check({name, " data"}, {if_data_o, mem_rdata_o}, 64'h0);
    endtask

    // RAM model: 64 KiB window on the low address bits, preloaded contents
    // come from init_byte until a location is written.
    bit [7:0] ram_mem [0:65535];
    bit       ram_vld [0:65535];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0200: return 8'h11;
            32'h0000_0201: return 8'h22;
            32'h0000_0202: return 8'h33;
            32'h0000_0203: return 8'h44;
            32'h0000_0204: return 8'h55;
            32'hFFFF_FFFF: return 8'h34;
            32'h0000_0000: return 8'h12;
            default:       return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_wr_o) begin
            ram_mem[ram_a_o[15:0]] <= ram_dout_o;
            ram_vld[ram_a_o[15:0]] <= 1'b1;
        end
        ram_din_i <= ram_vld[ram_a_o[15:0]] ? ram_mem[ram_a_o[15:0]] : init_byte(ram_a_o);
    end

    // Per-cycle log of the RAM port, index = cycles after the request cycle.
    logic [31:0] g_a    [0:31];
    logic        g_wr   [0:31];
    logic [7:0]  g_dout [0:31];

    task automatic sample(input int c);
        g_a[c]    = ram_a_o;
        g_wr[c]   = ram_wr_o;
        g_dout[c] = ram_dout_o;
    endtask

    typedef struct {
        string       name;
        logic        is_if;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic is_if, input logic we,
                                input logic [1:0] len, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic chk,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = nm; v.is_if = is_if; v.we = we; v.len = len; v.addr = addr;
        v.wdata = wdata; v.chk_data = chk; v.exp_data = exp; v.exp_lat = lat;
        return v;
    endfunction

    // One isolated transfer: request at cycle T, measure done latency and data.
    task automatic run_vec(input vec_t v);
        int          lat;
        logic [31:0] d;
        lat = -1;
        d   = 32'h0;
        @(posedge clk); #1;
        if (v.is_if) begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end else begin
            mem_req_i   = 1'b1;
            mem_we_i    = v.we;
            mem_len_i   = v.len;
            mem_addr_i  = v.addr;
            mem_wdata_i = v.wdata;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            sample(c);
            if (lat < 0 && (v.is_if ? if_done_o : mem_done_o)) begin
                lat = c;
                d   = v.is_if ? if_data_o : mem_rdata_o;
            end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        check({v.name, " latency"}, lat, v.exp_lat);
        if (v.chk_data) check({v.name, " data"}, d, v.exp_data);
        @(negedge clk);
        check({v.name, " idle after"}, {busy_o, if_done_o, mem_done_o}, 3'b000);
    endtask

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          md, md2, id, mcount;
        logic        both, ifd_seen, m_now;
        logic [31:0] idata;
        logic [7:0]  eb [4];
        logic        ew [1:8];
        logic [31:0] ea [1:8];
        logic [7:0]  ed [1:8];

        rst = 1'b1; rdy_in = 1'b1; flush_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
        mem_addr_i = '0; mem_wdata_i = '0;

        vecs[0]  = mk("fetch 0x100",    1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0013, 6);
        vecs[1]  = mk("ld byte 0x201",  1'b0, 1'b0, 2'b00, 32'h0000_0201, 32'h0, 1'b1, 32'h0000_0022, 3);
        vecs[2]  = mk("ld half 0x202",  1'b0, 1'b0, 2'b01, 32'h0000_0202, 32'h0, 1'b1, 32'h0000_4433, 4);
        vecs[3]  = mk("ld word len10",  1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 1'b1, 32'h4433_2211, 6);
        vecs[4]  = mk("ld word len11",  1'b0, 1'b0, 2'b11, 32'h0000_0200, 32'h0, 1'b1, 32'h4433_2211, 6);
        vecs[5]  = mk("ld half wrap",   1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_1234, 4);
        vecs[6]  = mk("ld word misal",  1'b0, 1'b0, 2'b10, 32'h0000_0201, 32'h0, 1'b1, 32'h5544_3322, 6);
        vecs[7]  = mk("st byte 0x300",  1'b0, 1'b1, 2'b00, 32'h0000_0300, 32'h1122_33AB, 1'b0, 32'h0, 3);
        vecs[8]  = mk("st half 0x310",  1'b0, 1'b1, 2'b01, 32'h0000_0310, 32'h1234_CDEF, 1'b0, 32'h0, 4);
        vecs[9]  = mk("ld word 0x310",  1'b0, 1'b0, 2'b10, 32'h0000_0310, 32'h0, 1'b1, 32'h0000_CDEF, 6);
        vecs[10] = mk("ld byte 0x300",  1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'h0, 1'b1, 32'h0000_00AB, 3);
        vecs[11] = mk("fetch 0x200",    1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 1'b1, 32'h4433_2211, 6);

        // Reset state, while asserted and after release.
        #3;
        check_zero("reset asserted");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("after reset");

        // Fetch: address sequence on the RAM port.
        run_vec(vecs[0]);
        check("fetch no addr in T", g_a[0], 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fetch addr T+%0d", k + 1), g_a[k + 1], 32'h100 + k);
        end
        check("fetch no addr in last xfer", g_a[5], 32'h0);

        for (int i = 1; i < NV; i++) begin
            run_vec(vecs[i]);
        end
        check("store byte in ram", ram_mem[16'h0300], 8'hAB);
        check("store half in ram", {ram_mem[16'h0311], ram_mem[16'h0310]}, 16'hCDEF);

        // Tie between a word store and a fetch: MEM first, IF afterwards.
        eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEAD_BEEF;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        md = -1; id = -1; both = 1'b0; idata = 32'h0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            sample(c);
            if (mem_done_o && if_done_o) both = 1'b1;
            if (mem_done_o) md = c;
            if (if_done_o) begin
                id    = c;
                idata = if_data_o;
            end
            @(posedge clk); #1;
            if (md == c) mem_req_i = 1'b0;
            if (id == c) if_req_i = 1'b0;
            if (md >= 0 && id >= 0) break;
        end
        mem_req_i = 1'b0; if_req_i = 1'b0; mem_we_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tie store write %0d", k),
                  {g_wr[k + 1], g_a[k + 1], g_dout[k + 1]}, {1'b1, 32'h2000 + k, eb[k]});
        end
        check("tie store no write last xfer", g_wr[5], 1'b0);
        check("tie mem_done cycle", md, 6);
        check("tie if_done cycle", id, 13);
        check("tie fetch data", idata, 32'h0000_0013);
        check("tie dones never together", both, 1'b0);
        check("tie ram word", {ram_mem[16'h2003], ram_mem[16'h2002], ram_mem[16'h2001], ram_mem[16'h2000]},
              32'hDEAD_BEEF);

        // Two consecutive ties: MEM re-requests right after its first load.
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h201;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        mcount = 0; md = -1; md2 = -1; id = -1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            m_now = mem_done_o;
            if (mem_done_o) begin
                mcount++;
                if (mcount == 1) md = c;
                else md2 = c;
            end
            if (if_done_o) id = c;
            @(posedge clk); #1;
            if (m_now && mcount >= 2) mem_req_i = 1'b0;
            if (id == c) if_req_i = 1'b0;
            if (mcount >= 2 && id >= 0) break;
        end
        mem_req_i = 1'b0; if_req_i = 1'b0;
        check("second tie first mem done", md, 3);
`ifdef MEM_ARB_RR_EN
        check("second tie if_done (IF wins)", id, 10);
        check("second tie mem done after IF", md2, 14);
`else
        check("second tie mem done (MEM wins)", md2, 7);
        check("second tie if_done after MEM", id, 14);
`endif

        // Flush in IDLE blocks the fetch grant for that cycle.
        @(posedge clk); #1;
        if_req_i = 1'b1; if_addr_i = 32'h100; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush in idle no grant", busy_o, 1'b0);
        // This cycle is T for the fetch; flush it at T+2.
        md = -1; ifd_seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 2) flush_i = 1'b1;
            if (c == 3) begin
                flush_i = 1'b0; if_req_i = 1'b0;
                mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h203;
            end
            if (md >= 0) mem_req_i = 1'b0;
            @(negedge clk);
            if (c == 3) check("flush returns to idle", busy_o, 1'b0);
            if (if_done_o) ifd_seen = 1'b1;
            if (mem_done_o && md < 0) md = c;
        end
        mem_req_i = 1'b0;
        check("flush suppresses if_done", ifd_seen, 1'b0);
        check("mem after flush done cycle", md, 6);

        // Pause for three cycles in the middle of a word store.
        ew[1] = 1'b1; ea[1] = 32'h400; ed[1] = 8'h01;
        for (int k = 2; k <= 4; k++) begin
            ew[k] = 1'b0; ea[k] = 32'h401; ed[k] = 8'h02;
        end
        ew[5] = 1'b1; ea[5] = 32'h401; ed[5] = 8'h02;
        ew[6] = 1'b1; ea[6] = 32'h402; ed[6] = 8'h03;
        ew[7] = 1'b1; ea[7] = 32'h403; ed[7] = 8'h04;
        ew[8] = 1'b0; ea[8] = 32'h0;   ed[8] = 8'h00;
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h400; mem_wdata_i = 32'h0403_0201;
        md = -1;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) rdy_in = 1'b0;
            if (c == 5) rdy_in = 1'b1;
            @(negedge clk);
            sample(c);
            if (mem_done_o && md < 0) md = c;
            @(posedge clk); #1;
            if (md >= 0) mem_req_i = 1'b0;
        end
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("pause store cycle %0d", k), {g_wr[k], g_a[k], g_dout[k]},
                  {ew[k], ea[k], ed[k]});
        end
        check("pause done delayed by 3", md, 9);
        check("pause ram word", {ram_mem[16'h0403], ram_mem[16'h0402], ram_mem[16'h0401], ram_mem[16'h0400]},
              32'h0403_0201);

        // Asynchronous reset in the middle of a word load.
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy before reset", busy_o, 1'b1);
        rst = 1'b1; mem_req_i = 1'b0;
        #2;
        check_zero("reset mid-transfer");
        #3 rst = 1'b0;
        md = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_done_o || if_done_o) md = c;
        end
        check("no done after reset", md, -1);
        check("idle after reset", busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
